// File: rtl/ros_meas_sequencer.sv
// Ring-oscillator measurement sequencer: clear, gate, latch, then select/send/shift per enabled oscillator.
// Optional ROS_SEQ_FRAME_ID_EN adds a frame counter; otherwise frame_id is tied to 0.
module ros_meas_sequencer #(
   parameter int COUNTER_LENGTH = 20,
   parameter int CLR_CYCLES     = 4,
   parameter int LATCH_CYCLES   = 8,
   parameter int SEND_CYCLES    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   input  logic       continuous,
   input  logic [2:0] osc_mask,
   input  logic [1:0] gate_sel,
   output logic       ctr_reset,
   output logic       latch_counter,
   output logic       send_counter,
   output logic [1:0] counter_select,
   output logic       busy,
   output logic       done,
   output logic [7:0] frame_id
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, GATE, LATCH, SELECT, SEND, SHIFT, DONE
   } state_t;

   localparam logic [15:0] CLR_LOAD   = 16'(CLR_CYCLES - 1);
   localparam logic [15:0] LATCH_LOAD = 16'(LATCH_CYCLES - 1);
   localparam logic [15:0] SEND_LOAD  = 16'(SEND_CYCLES - 1);
   localparam logic [15:0] SHIFT_LOAD = 16'(COUNTER_LENGTH + 6);

   state_t      state;
   logic [15:0] timer;
   logic [2:0]  mask_q;
   logic [1:0]  gate_q;

   function automatic logic [15:0] gate_load(input logic [1:0] g);
      case (g)
         2'd0:    gate_load = 16'd1023;
         2'd1:    gate_load = 16'd4095;
         2'd2:    gate_load = 16'd16383;
         default: gate_load = 16'hFFFF;
      endcase
   endfunction

   function automatic logic [1:0] lowest(input logic [2:0] m);
      lowest = m[0] ? 2'd0 : (m[1] ? 2'd1 : 2'd2);
   endfunction

   // mask_q doubles as the unserved set: each SELECT retires its lowest bit
   function automatic logic [2:0] drop_lowest(input logic [2:0] m);
      drop_lowest = m[0] ? {m[2:1], 1'b0} : (m[1] ? {m[2], 2'b00} : 3'b000);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || !ena) begin
         state          <= IDLE;
         timer          <= '0;
         mask_q         <= '0;
         gate_q         <= '0;
         ctr_reset      <= 1'b0;
         latch_counter  <= 1'b0;
         send_counter   <= 1'b0;
         counter_select <= 2'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && osc_mask != 3'b000) begin
                  state     <= CLEAR;
                  mask_q    <= osc_mask;
                  gate_q    <= gate_sel;
                  timer     <= CLR_LOAD;
                  ctr_reset <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            CLEAR: begin
               if (timer == 16'd0) begin
                  state     <= GATE;
                  ctr_reset <= 1'b0;
                  timer     <= gate_load(gate_q);
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            GATE: begin
               if (timer == 16'd0) begin
                  state         <= LATCH;
                  latch_counter <= 1'b1;
                  timer         <= LATCH_LOAD;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            LATCH: begin
               if (timer == 16'd0) begin
                  state          <= SELECT;
                  latch_counter  <= 1'b0;
                  counter_select <= lowest(mask_q);
                  mask_q         <= drop_lowest(mask_q);
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            SELECT: begin
               state        <= SEND;
               send_counter <= 1'b1;
               timer        <= SEND_LOAD;
            end
            SEND: begin
               if (timer == 16'd0) begin
                  state        <= SHIFT;
                  send_counter <= 1'b0;
                  timer        <= SHIFT_LOAD;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            SHIFT: begin
               if (timer == 16'd0) begin
                  if (mask_q != 3'b000) begin
                     state          <= SELECT;
                     counter_select <= lowest(mask_q);
                     mask_q         <= drop_lowest(mask_q);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            DONE: begin
               if (continuous && osc_mask != 3'b000) begin
                  state     <= CLEAR;
                  mask_q    <= osc_mask;
                  gate_q    <= gate_sel;
                  timer     <= CLR_LOAD;
                  ctr_reset <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ROS_SEQ_FRAME_ID_EN
   logic [7:0] frame_q;

   always_ff @(posedge clk) begin
      if (!rst_n || !ena) begin
         frame_q <= 8'd0;
      end else if (state == DONE) begin
         frame_q <= frame_q + 8'd1;
      end
   end

   assign frame_id = frame_q;
`else
   assign frame_id = 8'd0;
`endif

endmodule

// File: tb/tb_ros_meas_sequencer.sv
// Directed bench for ros_meas_sequencer: phase lengths, select order, restart, reset/enable aborts.
module tb_ros_meas_sequencer;

   localparam int FE =
`ifdef ROS_SEQ_FRAME_ID_EN
      1;
`else
      0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, ena, start, continuous;
   logic [2:0] osc_mask;
   logic [1:0] gate_sel;
   logic       ctr_reset, latch_counter, send_counter, busy, done;
   logic [1:0] counter_select;
   logic [7:0] frame_id;

   int checks   = 0;
   int failures = 0;
   int viol     = 0;
   int n;
   int total;
   int busy_seen;

   ros_meas_sequencer dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .continuous(continuous),
      .osc_mask(osc_mask), .gate_sel(gate_sel), .ctr_reset(ctr_reset),
      .latch_counter(latch_counter), .send_counter(send_counter),
      .counter_select(counter_select), .busy(busy), .done(done), .frame_id(frame_id)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ((int'(ctr_reset) + int'(latch_counter) + int'(send_counter)) > 1 || counter_select == 2'b11)
         viol = viol + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       sig = ctr_reset;
         1:       sig = latch_counter;
         2:       sig = send_counter;
         3:       sig = done;
         default: sig = busy;
      endcase
   endfunction

   // counts consecutive sampled cycles where the signal holds lvl, bounded by budget
   task automatic run_len(input int w, input logic lvl, input int budget, output int cnt);
      cnt = 0;
      while (sig(w) === lvl && cnt < budget) begin
         cnt++;
         tick();
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_clr"},   ctr_reset, 0);
      check({tag, "_latch"}, latch_counter, 0);
      check({tag, "_send"},  send_counter, 0);
      check({tag, "_sel"},   counter_select, 0);
      check({tag, "_frame"}, frame_id, 0);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; start = 1'b0; continuous = 1'b0;
      osc_mask = 3'b000; gate_sel = 2'd0;
      tick(); tick();
      check_idle("reset");
      rst_n = 1'b1;

      // single sweep, one oscillator, shortest gate
      osc_mask = 3'b001; start = 1'b1;
      tick();
      start = 1'b0;
      check("s1_clr_start", ctr_reset, 1);
      check("s1_busy", busy, 1);
      total = 0;
      run_len(0, 1'b1, 100, n);   check("s1_clr_len", n, 4);    total += n;
      run_len(1, 1'b0, 2000, n);  check("s1_gate_len", n, 1024); total += n;
      run_len(1, 1'b1, 100, n);   check("s1_latch_len", n, 8);  total += n;
      run_len(2, 1'b0, 100, n);   check("s1_select_len", n, 1); total += n;
      check("s1_sel", counter_select, 0);
      run_len(2, 1'b1, 100, n);   check("s1_send_len", n, 4);   total += n;
      run_len(3, 1'b0, 100, n);   check("s1_shift_len", n, 27); total += n;
      check("s1_done", done, 1);
      check("s1_total", total + 1, 1069);
      tick();
      check("s1_done_pulse", done, 0);
      check("s1_idle_busy", busy, 0);
      check("s1_frame", frame_id, FE * 1);

      // mask 101, mask input changed mid-sweep must not matter
      osc_mask = 3'b101; start = 1'b1;
      tick();
      start = 1'b0;
      osc_mask = 3'b010;
      run_len(2, 1'b0, 2000, n);  check("s2_to_send", n, 1037);
      check("s2_sel_a", counter_select, 0);
      run_len(2, 1'b1, 100, n);   check("s2_send_a", n, 4);
      run_len(2, 1'b0, 100, n);   check("s2_gap", n, 28);
      check("s2_sel_b", counter_select, 2);
      run_len(2, 1'b1, 100, n);   check("s2_send_b", n, 4);
      run_len(3, 1'b0, 100, n);   check("s2_shift_b", n, 27);
      check("s2_done", done, 1);
      tick();
      check("s2_idle", busy, 0);
      check("s2_frame", frame_id, FE * 2);

      // start with empty mask is ignored
      osc_mask = 3'b000; start = 1'b1; busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (busy !== 1'b0) busy_seen++;
      end
      start = 1'b0;
      check("s3_busy_cycles", busy_seen, 0);

      // continuous back-to-back sweeps from a fresh frame count
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("s4_frame0", frame_id, 0);
      osc_mask = 3'b111; continuous = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      run_len(3, 1'b0, 3000, n);  check("s4_len1", n, 1132);
      check("s4_done1", done, 1);
      tick();
      check("s4_restart1", ctr_reset, 1);
      check("s4_frame1", frame_id, FE * 1);
      run_len(3, 1'b0, 3000, n);  check("s4_len2", n, 1132);
      tick();
      check("s4_restart2", ctr_reset, 1);
      check("s4_frame2", frame_id, FE * 2);
      continuous = 1'b0;
      run_len(3, 1'b0, 3000, n);  check("s4_len3", n, 1132);
      check("s4_done3", done, 1);
      tick();
      check("s4_stop_busy", busy, 0);
      check("s4_stop_clr", ctr_reset, 0);
      check("s4_frame3", frame_id, FE * 3);

      // reset pulse mid-gate
      osc_mask = 3'b001; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 200; i++) tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check_idle("s5_rst");
      tick();
      check("s5_stay_idle", busy, 0);

      // enable drop mid-send with a nonzero select
      osc_mask = 3'b100; start = 1'b1;
      tick();
      start = 1'b0;
      run_len(2, 1'b0, 2000, n);
      check("s5_sel_pre", counter_select, 2);
      tick(); tick();
      ena = 1'b0; tick(); ena = 1'b1;
      check_idle("s5_ena");

      // gate_sel change during gate affects only the next sweep
      osc_mask = 3'b001; gate_sel = 2'd0; start = 1'b1;
      tick();
      start = 1'b0;
      run_len(0, 1'b1, 100, n);   check("s6_clr", n, 4);
      gate_sel = 2'd3;
      run_len(1, 1'b0, 2000, n);  check("s6_gate_old", n, 1024);
      run_len(3, 1'b0, 2000, n);
      check("s6_done", done, 1);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_len(0, 1'b1, 100, n);   check("s6_clr2", n, 4);
      run_len(1, 1'b0, 70000, n); check("s6_gate_new", n, 65536);

      check("exclusive_and_sel", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
